// File: rtl/stage_memory_access.sv
// Memory-access pipeline stage: one req/gnt/rvalid data-bus transaction per load/store.
// Optional MA_MISALIGN_TRAP_EN: misaligned H/W accesses skip the bus and retire flagged.
package stage_memory_access_pkg;
    typedef enum logic [1:0] {
        MA_X     = 2'd0,
        MA_LOAD  = 2'd1,
        MA_STORE = 2'd2
    } ma_mode_t;

    typedef enum logic [2:0] {
        MA_SIZE_B  = 3'b000,
        MA_SIZE_H  = 3'b001,
        MA_SIZE_W  = 3'b010,
        MA_SIZE_BU = 3'b100,
        MA_SIZE_HU = 3'b101
    } ma_size_t;

    typedef logic [4:0] regaddr_t;

    localparam logic [31:0] NOP_PC = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_IR = 32'h0000_0013;
endpackage

module stage_memory_access
    import stage_memory_access_pkg::*;
#(
    parameter int DMEM_ADDR_WIDTH = 30
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       ex_valid_i,
    output logic                       ex_ready_o,
    input  logic [31:0]                ex_pc_i,
    input  logic [31:0]                ex_ir_i,
    input  ma_mode_t                   ex_ma_mode_i,
    input  ma_size_t                   ex_ma_size_i,
    input  logic [31:0]                ex_ma_addr_i,
    input  logic [31:0]                ex_ma_data_i,
    input  regaddr_t                   ex_wb_addr_i,
    input  logic [31:0]                ex_wb_data_i,
    input  logic                       ex_wb_valid_i,
    output logic                       dmem_req_o,
    output logic                       dmem_we_o,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [3:0]                 dmem_wmask_o,
    output logic [31:0]                dmem_wdata_o,
    input  logic                       dmem_gnt_i,
    input  logic                       dmem_rvalid_i,
    input  logic [31:0]                dmem_rdata_i,
    output logic [31:0]                ma_pc_o,
    output logic [31:0]                ma_ir_o,
    output regaddr_t                   ma_wb_addr_o,
    output logic [31:0]                ma_wb_data_o,
    output logic                       ma_wb_valid_o,
    output logic                       ma_misaligned_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    function automatic logic [3:0] store_mask(ma_size_t s, logic [1:0] off);
        case (s)
            MA_SIZE_B, MA_SIZE_BU: return 4'b0001 << off;
            MA_SIZE_H, MA_SIZE_HU: return off[1] ? 4'b1100 : 4'b0011;
            default:               return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(ma_size_t s, logic [31:0] d);
        case (s)
            MA_SIZE_B, MA_SIZE_BU: return {4{d[7:0]}};
            MA_SIZE_H, MA_SIZE_HU: return {2{d[15:0]}};
            default:               return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(ma_size_t s, logic [1:0] off, logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (s)
            MA_SIZE_B:  return {{24{b[7]}}, b};
            MA_SIZE_BU: return {24'h0, b};
            MA_SIZE_H:  return {{16{h[15]}}, h};
            MA_SIZE_HU: return {16'h0, h};
            default:    return w;
        endcase
    endfunction

`ifdef MA_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(ma_size_t s, logic [1:0] off);
        case (s)
            MA_SIZE_B, MA_SIZE_BU: return 1'b0;
            MA_SIZE_H, MA_SIZE_HU: return off[0];
            default:               return off != 2'b00;
        endcase
    endfunction
`endif

    state_t                     state_q;
    logic [31:0]                pc_q, ir_q, wb_data_q;
    regaddr_t                   wb_addr_q;
    logic                       wb_valid_q, is_store_q;
    ma_size_t                   size_q;
    logic [1:0]                 off_q;
    logic                       dmem_req_q, dmem_we_q;
    logic [DMEM_ADDR_WIDTH-1:0] dmem_addr_q;
    logic [3:0]                 dmem_wmask_q;
    logic [31:0]                dmem_wdata_q;
    logic [31:0]                ma_pc_q, ma_ir_q, ma_wb_data_q;
    regaddr_t                   ma_wb_addr_q;
    logic                       ma_wb_valid_q;
    logic                       is_mem_op_d;

    assign is_mem_op_d = (ex_ma_mode_i == MA_LOAD) || (ex_ma_mode_i == MA_STORE);

`ifdef MA_MISALIGN_TRAP_EN
    logic ma_misaligned_q;
    logic misaligned_d;
    assign misaligned_d    = is_misaligned(ex_ma_size_i, ex_ma_addr_i[1:0]);
    assign ma_misaligned_o = ma_misaligned_q;
`else
    assign ma_misaligned_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            ir_q          <= '0;
            wb_data_q     <= '0;
            wb_addr_q     <= '0;
            wb_valid_q    <= 1'b0;
            is_store_q    <= 1'b0;
            size_q        <= MA_SIZE_W;
            off_q         <= '0;
            dmem_req_q    <= 1'b0;
            dmem_we_q     <= 1'b0;
            dmem_addr_q   <= '0;
            dmem_wmask_q  <= '0;
            dmem_wdata_q  <= '0;
            ma_pc_q       <= NOP_PC;
            ma_ir_q       <= NOP_IR;
            ma_wb_addr_q  <= '0;
            ma_wb_data_q  <= '0;
            ma_wb_valid_q <= 1'b0;
`ifdef MA_MISALIGN_TRAP_EN
            ma_misaligned_q <= 1'b0;
`endif
        end else begin
            // Retirement outputs are single-cycle; default back to a NOP
            ma_pc_q       <= NOP_PC;
            ma_ir_q       <= NOP_IR;
            ma_wb_addr_q  <= '0;
            ma_wb_data_q  <= '0;
            ma_wb_valid_q <= 1'b0;
`ifdef MA_MISALIGN_TRAP_EN
            ma_misaligned_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (ex_valid_i && !is_mem_op_d) begin
                        ma_pc_q       <= ex_pc_i;
                        ma_ir_q       <= ex_ir_i;
                        ma_wb_addr_q  <= ex_wb_addr_i;
                        ma_wb_data_q  <= ex_wb_data_i;
                        ma_wb_valid_q <= ex_wb_valid_i;
                    end
`ifdef MA_MISALIGN_TRAP_EN
                    else if (ex_valid_i && misaligned_d) begin
                        ma_pc_q         <= ex_pc_i;
                        ma_ir_q         <= ex_ir_i;
                        ma_wb_addr_q    <= ex_wb_addr_i;
                        ma_misaligned_q <= 1'b1;
                    end
`endif
                    else if (ex_valid_i) begin
                        pc_q         <= ex_pc_i;
                        ir_q         <= ex_ir_i;
                        wb_addr_q    <= ex_wb_addr_i;
                        wb_data_q    <= ex_wb_data_i;
                        wb_valid_q   <= ex_wb_valid_i;
                        is_store_q   <= (ex_ma_mode_i == MA_STORE);
                        size_q       <= ex_ma_size_i;
                        off_q        <= ex_ma_addr_i[1:0];
                        dmem_req_q   <= 1'b1;
                        dmem_we_q    <= (ex_ma_mode_i == MA_STORE);
                        dmem_addr_q  <= ex_ma_addr_i[DMEM_ADDR_WIDTH+1:2];
                        dmem_wmask_q <= (ex_ma_mode_i == MA_STORE) ?
                                        store_mask(ex_ma_size_i, ex_ma_addr_i[1:0]) : 4'b1111;
                        dmem_wdata_q <= store_data(ex_ma_size_i, ex_ma_data_i);
                        state_q      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (dmem_gnt_i) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        if (is_store_q) begin
                            ma_pc_q       <= pc_q;
                            ma_ir_q       <= ir_q;
                            ma_wb_addr_q  <= wb_addr_q;
                            ma_wb_data_q  <= wb_data_q;
                            ma_wb_valid_q <= wb_valid_q;
                            state_q       <= S_IDLE;
                        end else begin
                            state_q <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (dmem_rvalid_i) begin
                        ma_pc_q       <= pc_q;
                        ma_ir_q       <= ir_q;
                        ma_wb_addr_q  <= wb_addr_q;
                        ma_wb_data_q  <= load_extract(size_q, off_q, dmem_rdata_i);
                        ma_wb_valid_q <= wb_valid_q;
                        state_q       <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ex_ready_o    = (state_q == S_IDLE);
    assign dmem_req_o    = dmem_req_q;
    assign dmem_we_o     = dmem_we_q;
    assign dmem_addr_o   = dmem_addr_q;
    assign dmem_wmask_o  = dmem_wmask_q;
    assign dmem_wdata_o  = dmem_wdata_q;
    assign ma_pc_o       = ma_pc_q;
    assign ma_ir_o       = ma_ir_q;
    assign ma_wb_addr_o  = ma_wb_addr_q;
    assign ma_wb_data_o  = ma_wb_data_q;
    assign ma_wb_valid_o = ma_wb_valid_q;

endmodule

// File: tb/tb_stage_memory_access.sv
// Scoreboard bench for stage_memory_access: directed stimulus queues expected retirements,
// a negedge monitor pops and compares them (including the retirement cycle).
module tb_stage_memory_access;
    import stage_memory_access_pkg::*;

    localparam int AW = 30;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          ex_valid_i;
    logic          ex_ready_o;
    logic [31:0]   ex_pc_i, ex_ir_i, ex_ma_addr_i, ex_ma_data_i, ex_wb_data_i;
    ma_mode_t      ex_ma_mode_i;
    ma_size_t      ex_ma_size_i;
    regaddr_t      ex_wb_addr_i;
    logic          ex_wb_valid_i;
    logic          dmem_req_o, dmem_we_o;
    logic [AW-1:0] dmem_addr_o;
    logic [3:0]    dmem_wmask_o;
    logic [31:0]   dmem_wdata_o;
    logic          dmem_gnt_i, dmem_rvalid_i;
    logic [31:0]   dmem_rdata_i;
    logic [31:0]   ma_pc_o, ma_ir_o, ma_wb_data_o;
    regaddr_t      ma_wb_addr_o;
    logic          ma_wb_valid_o, ma_misaligned_o;

    stage_memory_access #(.DMEM_ADDR_WIDTH(AW)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .ex_pc_i(ex_pc_i), .ex_ir_i(ex_ir_i),
        .ex_ma_mode_i(ex_ma_mode_i), .ex_ma_size_i(ex_ma_size_i),
        .ex_ma_addr_i(ex_ma_addr_i), .ex_ma_data_i(ex_ma_data_i),
        .ex_wb_addr_i(ex_wb_addr_i), .ex_wb_data_i(ex_wb_data_i), .ex_wb_valid_i(ex_wb_valid_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wmask_o(dmem_wmask_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .ma_pc_o(ma_pc_o), .ma_ir_o(ma_ir_o), .ma_wb_addr_o(ma_wb_addr_o),
        .ma_wb_data_o(ma_wb_data_o), .ma_wb_valid_o(ma_wb_valid_o),
        .ma_misaligned_o(ma_misaligned_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        wb_valid;
        logic        mis;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push(logic [31:0] pc, logic [31:0] ir, logic [4:0] wa,
                                 logic [31:0] wd, logic wv, logic mis, int c);
        exp_t e;
        e.pc = pc; e.ir = ir; e.wb_addr = wa; e.wb_data = wd;
        e.wb_valid = wv; e.mis = mis; e.cyc = c;
        sb.push_back(e);
    endfunction

    // Monitor: any non-NOP PC is a retirement and must match the head of the scoreboard
    always @(negedge clk_i) begin
        exp_t e;
        if (!reset_i) begin
            if (ma_pc_o !== 32'hFFFF_FFFF) begin
                if (sb.size() == 0) begin
                    chk("unexpected_retire_pc", ma_pc_o, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("ret_pc", ma_pc_o, e.pc);
                    chk("ret_ir", ma_ir_o, e.ir);
                    chk("ret_wb_addr", {27'h0, ma_wb_addr_o}, {27'h0, e.wb_addr});
                    chk("ret_wb_data", ma_wb_data_o, e.wb_data);
                    chk("ret_wb_valid", {31'h0, ma_wb_valid_o}, {31'h0, e.wb_valid});
                    chk("ret_misaligned", {31'h0, ma_misaligned_o}, {31'h0, e.mis});
                    chk("ret_cycle", cyc, e.cyc);
                end
            end else begin
                chk("nop_ir", ma_ir_o, 32'h0000_0013);
                chk("nop_wb_data", ma_wb_data_o, 32'h0);
                chk("nop_ctrl", {25'h0, ma_wb_valid_o, ma_misaligned_o, ma_wb_addr_o}, 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(ma_mode_t m, ma_size_t s, logic [31:0] a, logic [31:0] d,
                         logic [31:0] pc, logic [31:0] ir, logic [4:0] wa,
                         logic [31:0] wd, logic wv);
        ex_valid_i    = 1'b1;
        ex_ma_mode_i  = m;
        ex_ma_size_i  = s;
        ex_ma_addr_i  = a;
        ex_ma_data_i  = d;
        ex_pc_i       = pc;
        ex_ir_i       = ir;
        ex_wb_addr_i  = wa;
        ex_wb_data_i  = wd;
        ex_wb_valid_i = wv;
    endtask

    task automatic do_store(ma_size_t s, logic [31:0] a, logic [31:0] d, logic [3:0] exp_mask,
                            logic [31:0] exp_wdata, int gw, logic [31:0] pc);
        int n;
        n = cyc;
        chk("st_ready_idle", {31'h0, ex_ready_o}, 32'h1);
        drive(MA_STORE, s, a, d, pc, 32'h0000_2023, 5'd0, 32'h0, 1'b0);
        push(pc, 32'h0000_2023, 5'd0, 32'h0, 1'b0, 1'b0, n + 2 + gw);
        tick();
        ex_valid_i = 1'b0;
        for (int i = 0; i <= gw; i++) begin
            chk("st_req", {31'h0, dmem_req_o}, 32'h1);
            chk("st_we", {31'h0, dmem_we_o}, 32'h1);
            chk("st_mask", {28'h0, dmem_wmask_o}, {28'h0, exp_mask});
            chk("st_wdata", dmem_wdata_o, exp_wdata);
            chk("st_addr", {2'b00, dmem_addr_o}, a >> 2);
            chk("st_ready_busy", {31'h0, ex_ready_o}, 32'h0);
            if (i == gw) dmem_gnt_i = 1'b1;
            tick();
        end
        dmem_gnt_i = 1'b0;
        chk("st_req_after_gnt", {31'h0, dmem_req_o}, 32'h0);
        chk("st_ready_after", {31'h0, ex_ready_o}, 32'h1);
    endtask

    task automatic do_load(ma_size_t s, logic [31:0] a, logic [31:0] rd, logic [31:0] exp,
                           int gw, int rw, logic [31:0] pc, logic [4:0] wa);
        int n;
        n = cyc;
        chk("ld_ready_idle", {31'h0, ex_ready_o}, 32'h1);
        drive(MA_LOAD, s, a, 32'h5555_5555, pc, 32'h0000_2003, wa, 32'h0, 1'b1);
        push(pc, 32'h0000_2003, wa, exp, 1'b1, 1'b0, n + 3 + gw + rw);
        tick();
        ex_valid_i = 1'b0;
        for (int i = 0; i <= gw; i++) begin
            chk("ld_req", {31'h0, dmem_req_o}, 32'h1);
            chk("ld_we", {31'h0, dmem_we_o}, 32'h0);
            chk("ld_mask", {28'h0, dmem_wmask_o}, 32'hF);
            chk("ld_addr", {2'b00, dmem_addr_o}, a >> 2);
            chk("ld_ready_req", {31'h0, ex_ready_o}, 32'h0);
            if (i == gw) dmem_gnt_i = 1'b1;
            tick();
        end
        dmem_gnt_i = 1'b0;
        for (int i = 0; i <= rw; i++) begin
            chk("ld_req_resp", {31'h0, dmem_req_o}, 32'h0);
            chk("ld_ready_resp", {31'h0, ex_ready_o}, 32'h0);
            if (i == rw) begin
                dmem_rvalid_i = 1'b1;
                dmem_rdata_i  = rd;
            end
            tick();
        end
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'hDEAD_DEAD;
        chk("ld_ready_after", {31'h0, ex_ready_o}, 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset_i       = 1'b1;
        ex_valid_i    = 1'b0;
        ex_ma_mode_i  = MA_X;
        ex_ma_size_i  = MA_SIZE_W;
        ex_ma_addr_i  = 32'h0;
        ex_ma_data_i  = 32'h0;
        ex_pc_i       = 32'h0;
        ex_ir_i       = 32'h0;
        ex_wb_addr_i  = 5'd0;
        ex_wb_data_i  = 32'h0;
        ex_wb_valid_i = 1'b0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'h0;
        #3;
        chk("rst_ready", {31'h0, ex_ready_o}, 32'h1);
        chk("rst_req_we", {30'h0, dmem_req_o, dmem_we_o}, 32'h0);
        chk("rst_mask", {28'h0, dmem_wmask_o}, 32'h0);
        chk("rst_addr", {2'b00, dmem_addr_o}, 32'h0);
        chk("rst_wdata", dmem_wdata_o, 32'h0);
        chk("rst_pc", ma_pc_o, 32'hFFFF_FFFF);
        chk("rst_ir", ma_ir_o, 32'h0000_0013);
        chk("rst_wb", {25'h0, ma_wb_valid_o, ma_misaligned_o, ma_wb_addr_o}, 32'h0);
        chk("rst_wb_data", ma_wb_data_o, 32'h0);
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        tick();

        // Four back-to-back pass-through ops
        for (int i = 1; i <= 4; i++) begin
            chk("x_ready", {31'h0, ex_ready_o}, 32'h1);
            drive(MA_X, MA_SIZE_W, 32'h0, 32'h0, 32'h100 + 4 * i, 32'h0000_0093 + (i << 7),
                  5'(i), i, 1'b1);
            push(32'h100 + 4 * i, 32'h0000_0093 + (i << 7), 5'(i), i, 1'b1, 1'b0, cyc + 1);
            tick();
        end
        ex_valid_i = 1'b0;
        chk("x_ready_end", {31'h0, ex_ready_o}, 32'h1);
        tick();

        do_store(MA_SIZE_B, 32'h0000_1003, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB, 2, 32'h200);
        do_store(MA_SIZE_H, 32'h0000_2002, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD, 0, 32'h204);
        do_store(MA_SIZE_W, 32'h0000_2004, 32'h8765_4321, 4'b1111, 32'h8765_4321, 1, 32'h208);

        do_load(MA_SIZE_B,  32'h0000_2001, 32'h1234_80FF, 32'hFFFF_FF80, 0, 0, 32'h300, 5'd5);
        do_load(MA_SIZE_BU, 32'h0000_2001, 32'h1234_80FF, 32'h0000_0080, 0, 0, 32'h304, 5'd6);
        do_load(MA_SIZE_HU, 32'h0000_2002, 32'h1234_80FF, 32'h0000_1234, 0, 0, 32'h308, 5'd7);
        do_load(MA_SIZE_H,  32'h0000_2002, 32'h8765_0000, 32'hFFFF_8765, 0, 1, 32'h30C, 5'd8);
        do_load(MA_SIZE_W,  32'h0000_2000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3, 2, 32'h310, 5'd9);
        do_load(ma_size_t'(3'b011), 32'h0000_2000, 32'hC0DE_1234, 32'hC0DE_1234, 0, 0,
                32'h314, 5'd10);

`ifdef MA_MISALIGN_TRAP_EN
        n = cyc;
        drive(MA_LOAD, MA_SIZE_W, 32'h0000_3002, 32'h0, 32'h400, 32'h0000_2003, 5'd11,
              32'h0, 1'b1);
        push(32'h400, 32'h0000_2003, 5'd11, 32'h0, 1'b0, 1'b1, n + 1);
        tick();
        ex_valid_i = 1'b0;
        chk("mis_no_req", {31'h0, dmem_req_o}, 32'h0);
        chk("mis_ready", {31'h0, ex_ready_o}, 32'h1);
        tick();
`else
        do_load(MA_SIZE_W, 32'h0000_3002, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 0, 32'h400, 5'd11);
`endif

        // Reset while a load waits for its response; the late rvalid must be dropped
        n = cyc;
        drive(MA_LOAD, MA_SIZE_W, 32'h0000_4000, 32'h0, 32'h500, 32'h0000_2003, 5'd12,
              32'h0, 1'b1);
        tick();
        ex_valid_i = 1'b0;
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        chk("rr_in_resp", {31'h0, ex_ready_o}, 32'h0);
        #2;
        reset_i = 1'b1;
        #1;
        chk("rr_ready", {31'h0, ex_ready_o}, 32'h1);
        chk("rr_req", {31'h0, dmem_req_o}, 32'h0);
        chk("rr_mask", {28'h0, dmem_wmask_o}, 32'h0);
        chk("rr_addr", {2'b00, dmem_addr_o}, 32'h0);
        chk("rr_pc", ma_pc_o, 32'hFFFF_FFFF);
        #2;
        reset_i = 1'b0;
        tick();
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h1111_2222;
        tick();
        dmem_rvalid_i = 1'b0;
        chk("rr_ready_after", {31'h0, ex_ready_o}, 32'h1);
        repeat (3) tick();

        chk("sb_empty", sb.size(), 32'h0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
